// File: rtl/warp_issue_sched.sv
// rtl/warp_issue_sched.sv - per-cycle warp issue scheduler, round-robin with long-latency unit reservation
// Optional WS_GTO_EN selects greedy-then-oldest arbitration instead of round-robin.
module warp_issue_sched #(
  parameter int NUM_WARPS = 8,
  parameter int WID_W     = 3,
  parameter int LONG_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WARPS-1:0] ActiveWarp_TM_WS,
  input  logic [NUM_WARPS-1:0] Ready_IB_WS,
  input  logic [NUM_WARPS-1:0] NoHazard_SB_WS,
  input  logic [NUM_WARPS-1:0] Stall_SIMT_WS,
  input  logic [NUM_WARPS-1:0] LongOp_IB_WS,
  input  logic                 Stall_EX_WS,
  output logic [NUM_WARPS-1:0] Issue_WS_IB,
  output logic                 Valid_WS_RF,
  output logic [WID_W-1:0]     WarpID_WS_RF,
  output logic                 LongBusy_WS
);

  localparam int LCNT_W = $clog2(LONG_LAT) + 1;

  logic [WID_W-1:0]     last_q;
  logic [LCNT_W-1:0]    lcnt_q;
  logic [NUM_WARPS-1:0] elig;
  logic                 gnt_valid;
  logic [WID_W-1:0]     gnt_id;

  assign LongBusy_WS = (lcnt_q != '0);

  always_comb begin
    elig = ActiveWarp_TM_WS & Ready_IB_WS & NoHazard_SB_WS & ~Stall_SIMT_WS &
           ~(LongOp_IB_WS & {NUM_WARPS{LongBusy_WS}});
    if (Stall_EX_WS || rst) elig = '0;
  end

  // Candidates are visited from lowest to highest priority so the last hit wins.
  always_comb begin
    logic [WID_W-1:0] idx;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
`ifdef WS_GTO_EN
    if (elig[last_q]) begin
      gnt_valid = 1'b1;
      gnt_id    = last_q;
    end else begin
      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
        idx = WID_W'(i);
        if (elig[idx]) begin
          gnt_valid = 1'b1;
          gnt_id    = idx;
        end
      end
    end
`else
    for (int k = NUM_WARPS; k >= 1; k--) begin
      idx = WID_W'((int'(last_q) + k) % NUM_WARPS);
      if (elig[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
`endif
  end

  assign Issue_WS_IB = gnt_valid ? (NUM_WARPS'(1) << gnt_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= WID_W'(NUM_WARPS - 1);
      lcnt_q       <= '0;
      Valid_WS_RF  <= 1'b0;
      WarpID_WS_RF <= '0;
    end else begin
      Valid_WS_RF <= gnt_valid;
      if (gnt_valid) begin
        last_q       <= gnt_id;
        WarpID_WS_RF <= gnt_id;
      end
      if (gnt_valid && LongOp_IB_WS[gnt_id]) lcnt_q <= LCNT_W'(LONG_LAT - 1);
      else if (lcnt_q != '0)                 lcnt_q <= lcnt_q - LCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_warp_issue_sched.sv
// tb/tb_warp_issue_sched.sv - directed vector bench for warp_issue_sched
module tb_warp_issue_sched;

  typedef struct {
    logic [7:0] act, rdy, nhz, simt, lng;
    logic       sex;
    logic [7:0] iss;
    logic       vld;
    logic [2:0] wid;
    logic       bsy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] active, ready, nohaz, stall_simt, longop;
  logic       stall_ex;
  logic [7:0] issue;
  logic       valid;
  logic [2:0] warp_id;
  logic       long_busy;

  int   errors = 0;
  int   checks = 0;
  vec_t tv[$];

  warp_issue_sched #(.NUM_WARPS(8), .WID_W(3), .LONG_LAT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ActiveWarp_TM_WS (active),
    .Ready_IB_WS      (ready),
    .NoHazard_SB_WS   (nohaz),
    .Stall_SIMT_WS    (stall_simt),
    .LongOp_IB_WS     (longop),
    .Stall_EX_WS      (stall_ex),
    .Issue_WS_IB      (issue),
    .Valid_WS_RF      (valid),
    .WarpID_WS_RF     (warp_id),
    .LongBusy_WS      (long_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] a, r, n, s, l, input logic x,
                     input logic [7:0] i, input logic v, input logic [2:0] w, input logic b);
    vec_t e;
    e.act = a; e.rdy = r; e.nhz = n; e.simt = s; e.lng = l; e.sex = x;
    e.iss = i; e.vld = v; e.wid = w; e.bsy = b;
    tv.push_back(e);
  endtask

  task automatic drive(input logic [7:0] a, r, n, s, l, input logic x);
    active = a; ready = r; nohaz = n; stall_simt = s; longop = l; stall_ex = x;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    #2;
    chk("reset issue", issue, 8'h00);
    chk("reset valid", {7'd0, valid}, 8'h00);
    chk("reset wid", {5'd0, warp_id}, 8'h00);
    chk("reset busy", {7'd0, long_busy}, 8'h00);
    next_cycle();
    rst = 1'b0;

`ifndef WS_GTO_EN
    // all warps eligible: plain rotation
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h01,0,3'd0,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h02,1,3'd0,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h04,1,3'd1,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h08,1,3'd2,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h10,1,3'd3,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h20,1,3'd4,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h40,1,3'd5,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h80,1,3'd6,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h01,1,3'd7,0);
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,0, 8'h02,1,3'd0,0);
    // warps 2 and 5, warp 2 SIMT-stalled then released
    add(8'hFF,8'h24,8'hFF,8'h04,8'h00,0, 8'h20,1,3'd1,0);
    add(8'hFF,8'h24,8'hFF,8'h04,8'h00,0, 8'h20,1,3'd5,0);
    add(8'hFF,8'h24,8'hFF,8'h04,8'h00,0, 8'h20,1,3'd5,0);
    add(8'hFF,8'h24,8'hFF,8'h00,8'h00,0, 8'h04,1,3'd5,0);
    add(8'hFF,8'h24,8'hFF,8'h00,8'h00,0, 8'h20,1,3'd2,0);
    add(8'hFF,8'h24,8'hFF,8'h00,8'h00,0, 8'h04,1,3'd5,0);
    // warps 1 and 3 both long: one every LONG_LAT cycles
    add(8'hFF,8'h0A,8'hFF,8'h00,8'h0A,0, 8'h08,1,3'd2,0);
    add(8'hFF,8'h0A,8'hFF,8'h00,8'h0A,0, 8'h00,1,3'd3,1);
    add(8'hFF,8'h0A,8'hFF,8'h00,8'h0A,0, 8'h00,0,3'd3,1);
    add(8'hFF,8'h0A,8'hFF,8'h00,8'h0A,0, 8'h00,0,3'd3,1);
    add(8'hFF,8'h0A,8'hFF,8'h00,8'h0A,0, 8'h02,0,3'd3,0);
    // warp 1 long, warp 6 short: short warp keeps issuing while busy
    add(8'hFF,8'h42,8'hFF,8'h00,8'h02,0, 8'h40,1,3'd1,1);
    add(8'hFF,8'h42,8'hFF,8'h00,8'h02,0, 8'h40,1,3'd6,1);
    add(8'hFF,8'h42,8'hFF,8'h00,8'h02,0, 8'h40,1,3'd6,1);
    add(8'hFF,8'h42,8'hFF,8'h00,8'h02,0, 8'h02,1,3'd6,0);
    add(8'hFF,8'h42,8'hFF,8'h00,8'h02,0, 8'h40,1,3'd1,1);
    // downstream stall holds pointer, counter keeps draining
    add(8'hFF,8'h0F,8'hFF,8'h00,8'h00,1, 8'h00,1,3'd6,1);
    add(8'hFF,8'h0F,8'hFF,8'h00,8'h00,1, 8'h00,0,3'd6,1);
    add(8'hFF,8'h0F,8'hFF,8'h00,8'h00,0, 8'h01,0,3'd6,0);
    add(8'hFF,8'h0F,8'hFF,8'h00,8'h00,0, 8'h02,1,3'd0,0);
    // stall with everything eligible, inactive warps, hazard
    add(8'hFF,8'hFF,8'hFF,8'h00,8'h00,1, 8'h00,1,3'd1,0);
    add(8'h00,8'hFF,8'hFF,8'h00,8'h00,0, 8'h00,0,3'd1,0);
    add(8'h01,8'hFF,8'hFE,8'h00,8'h00,0, 8'h00,0,3'd1,0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].act, tv[i].rdy, tv[i].nhz, tv[i].simt, tv[i].lng, tv[i].sex);
      @(negedge clk);
      chk($sformatf("v%0d issue", i), issue, tv[i].iss);
      chk($sformatf("v%0d valid", i), {7'd0, valid}, {7'd0, tv[i].vld});
      chk($sformatf("v%0d wid", i), {5'd0, warp_id}, {5'd0, tv[i].wid});
      chk($sformatf("v%0d busy", i), {7'd0, long_busy}, {7'd0, tv[i].bsy});
      next_cycle();
    end

    // reset in the middle of a reservation
    drive(8'hFF, 8'h20, 8'hFF, 8'h00, 8'h20, 1'b0);
    @(negedge clk);
    chk("rsv grant", issue, 8'h20);
    next_cycle();
    @(negedge clk);
    chk("rsv blocked", issue, 8'h00);
    chk("rsv busy", {7'd0, long_busy}, 8'h01);
    @(posedge clk);
    #2;
    chk("rsv busy2", {7'd0, long_busy}, 8'h01);
    chk("rsv wid", {5'd0, warp_id}, 8'h05);
    rst = 1'b1;
    #1;
    chk("midrst issue", issue, 8'h00);
    chk("midrst valid", {7'd0, valid}, 8'h00);
    chk("midrst wid", {5'd0, warp_id}, 8'h00);
    chk("midrst busy", {7'd0, long_busy}, 8'h00);
    next_cycle();
    rst = 1'b0;
    drive(8'hFF, 8'h21, 8'hFF, 8'h00, 8'h21, 1'b0);
    @(negedge clk);
    chk("post rst issue", issue, 8'h01);
    chk("post rst busy", {7'd0, long_busy}, 8'h00);
    next_cycle();
    @(negedge clk);
    chk("post rst blocked", issue, 8'h00);
    chk("post rst busy2", {7'd0, long_busy}, 8'h01);
    chk("post rst valid", {7'd0, valid}, 8'h01);
    chk("post rst wid", {5'd0, warp_id}, 8'h00);
`else
    drive(8'hFF, 8'h11, 8'hFF, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("gto first", issue, 8'h01);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(8'hFF, 8'h91, 8'hFF, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk($sformatf("gto greedy%0d", i), issue, 8'h01);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(8'hFF, 8'h90, 8'hFF, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk($sformatf("gto oldest%0d", i), issue, 8'h10);
    end
    next_cycle();
    @(negedge clk);
    chk("gto wid", {5'd0, warp_id}, 8'h04);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/warp_issue_sched.md
Name: warp_issue_sched

Overview:
- Per-cycle warp issue scheduler between the IBuffer and the register-read/execute stage.
- Selects at most one of 8 warps each cycle. A warp must have a valid head instruction, no scoreboard hazard and no SIMT-stack stall.
- Arbitration is round-robin, with reservation of the shared long-latency (DotS/multiply) unit.
- Grant is combinational to the IBuffer (dequeue); the issued warp ID is registered toward the next stage.

Parameters:
- NUM_WARPS, 8, number of warps; width of all per-warp vectors.
- WID_W, 3, warp ID width, equal to log2(NUM_WARPS).
- LONG_LAT, 4, initiation interval of the shared long-latency unit in cycles; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ActiveWarp_TM_WS  input  NUM_WARPS  warp is allocated by the Task Manager.
- Ready_IB_WS  input  NUM_WARPS  IBuffer holds a valid head instruction for the warp.
- NoHazard_SB_WS  input  NUM_WARPS  scoreboard clears the warp's head instruction.
- Stall_SIMT_WS  input  NUM_WARPS  SIMT stack stalls the warp (branch or reconvergence pending).
- LongOp_IB_WS  input  NUM_WARPS  warp's head instruction needs the shared long-latency unit.
- Stall_EX_WS  input  1  downstream backpressure; no issue this cycle.
- Issue_WS_IB  output  NUM_WARPS  one-hot combinational grant; the IBuffer dequeues the granted warp this cycle.
- Valid_WS_RF  output  1  registered: an instruction was issued in the previous cycle.
- WarpID_WS_RF  output  WID_W  registered ID of the issued warp.
- LongBusy_WS  output  1  shared long-latency unit is reserved.

Behaviour:
- Eligibility, per warp i:
  - elig[i] = ActiveWarp[i] & Ready[i] & NoHazard[i] & ~Stall_SIMT[i] & ~(LongOp[i] & LongBusy_WS).
  - If Stall_EX_WS=1, no warp is eligible.
- Arbitration:
  - Round-robin pointer last_q (WID_W bits) holds the most recently granted warp.
  - Search order is last_q+1, last_q+2, … modulo NUM_WARPS, ending with last_q itself.
  - The first eligible warp in that order wins. Issue_WS_IB is one-hot, or all zero if no warp is eligible.
- Pointer update: last_q is updated only on a grant; otherwise it holds.
- Output register, latency 1 cycle:
  - On a grant in cycle T: Valid_WS_RF=1 and WarpID_WS_RF=granted ID during cycle T+1.
  - With no grant: Valid_WS_RF=0 and WarpID_WS_RF holds its previous value.
- Long-latency counter lcnt_q, width ceil(log2(LONG_LAT))+1:
  - A grant to a warp with LongOp=1 loads LONG_LAT-1.
  - Otherwise, if nonzero, the counter decrements.
  - LongBusy_WS = (lcnt_q != 0).
  - Result: a long op issued at T blocks further long ops during T+1 … T+LONG_LAT-1; the next long op may issue at T+LONG_LAT.
  - LONG_LAT=1 never sets busy.
- Non-long ops:
  - A non-long warp is never blocked by LongBusy_WS.
  - While busy, long-op warps are skipped and other warps win.
- Simultaneous events:
  - A warp that becomes eligible in the same cycle its Stall_SIMT falls may be granted that cycle; all inputs are sampled combinationally.
  - If Stall_EX_WS and all elig are true together, Stall_EX_WS wins: no grant, pointer holds, counter still decrements.
- Reset (asynchronous, including mid-operation):
  - last_q = NUM_WARPS-1, so warp 0 has first priority.
  - lcnt_q = 0; Valid_WS_RF = 0; WarpID_WS_RF = 0; LongBusy_WS = 0.
  - Issue_WS_IB = 0 while rst is high.
  - A reservation in progress is discarded.
- Inactive warps (ActiveWarp=0) are never granted, regardless of other inputs.

Optional Feature:
- Macro: WS_GTO_EN.
- Defined (greedy-then-oldest): if warp last_q is eligible, it is granted again (greedy). Otherwise the lowest eligible warp ID is granted (oldest proxy: warp IDs are allocated in age order by the Task Manager). Pointer update and all other rules are unchanged.
- Undefined: pure round-robin as specified above.

Test Plan:
- Reset, then all 8 warps eligible with no LongOp, no stalls, for 10 cycles -> Issue_WS_IB = 0x01, 0x02, 0x04, …, 0x80, 0x01, 0x02. WarpID_WS_RF follows one cycle later: 0, 1, …, 7, 0, 1. Valid_WS_RF=1 from cycle 2.
- Warps 2 and 5 eligible, with Stall_SIMT_WS=0x04 for 3 cycles -> only warp 5 is granted (0x20) in each of those cycles. After the stall drops, grants alternate 0x04, 0x20.
- Warps 1 and 3 both LongOp=1 and eligible, LONG_LAT=4 -> warp 1 issues at T. LongBusy=1 during T+1..T+3 and Issue=0 in those cycles. Warp 3 issues at T+4.
- Warp 1 LongOp, warp 6 non-long, both eligible -> T: warp 1; T+1: warp 6 issues while LongBusy=1.
- Stall_EX_WS=1 for 2 cycles with warps 0–3 eligible -> Issue=0 and Valid_WS_RF=0, pointer unchanged. On release, the grant resumes at the warp after the last granted one.
- Assert rst mid-reservation (lcnt_q=2) -> outputs go to 0 immediately. After release, warp 0 wins first and a LongOp warp issues without waiting.
- With WS_GTO_EN defined and warps 0, 4, 7 eligible continuously -> warp 0 is granted every cycle. When warp 0 drops, warp 4 is granted repeatedly.
